// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_queue
// Purpose  : Merges ALU and load write requests into an in-order FIFO and
//            drains one write per cycle onto the register file write port.
// Revision : 1.0
// ============================================================================
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    output logic [31:0] pending,
    output logic        empty
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

    logic [4:0]       fifo_reg_q  [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic        w_full;
    logic        w_accept;
    logic [4:0]  w_in_reg;
    logic [31:0] w_in_data;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_pend;

    assign w_full    = (count_q == c_DEPTH);
    assign alu_ready = !w_full;
    assign mem_ready = !w_full && !alu_valid;

    assign w_accept  = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    assign w_in_reg  = alu_valid ? alu_reg  : mem_reg;
    assign w_in_data = alu_valid ? alu_data : mem_data;
    // Writes to r0 are handshaken but dropped so they never reach the port.
    assign w_push    = w_accept && (w_in_reg != 5'd0);
    assign w_pop     = (count_q != '0);

    always_comb begin
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            RegWrite <= w_pop;
            if (w_pop) begin
                WriteRegister <= fifo_reg_q[rd_ptr_q];
                WriteData     <= fifo_data_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: only slots inside [rd_ptr, rd_ptr+count) are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_reg_q[wr_ptr_q]  <= w_in_reg;
            fifo_data_q[wr_ptr_q] <= w_in_data;
        end
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        w_pend = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                w_pend[fifo_reg_q[i]] = 1'b1;
            end
        end
        if (RegWrite) begin
            w_pend[WriteRegister] = 1'b1;
        end
    end

    assign pending = w_pend & ~32'd1;
    assign empty   = (count_q == '0) && !RegWrite;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_queue
// Purpose  : Scoreboard bench with a queue-based reference model and
//            directed plus randomized request traffic.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] pending;
    logic        empty;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t mq[$];
    ent_t sb[$];
    bit   out_v = 1'b0;
    ent_t out_e = '0;
    bit   m_room, m_acc;
    ent_t m_new;

    regfile_write_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .pending(pending), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of outstanding writes plus the output slot.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sb.delete();
            out_v = 1'b0;
            out_e = '0;
        end else begin
            m_room = (mq.size() < DEPTH);
            m_acc  = m_room && (alu_valid || mem_valid);
            m_new  = alu_valid ? {alu_reg, alu_data} : {mem_reg, mem_data};
            if (mq.size() != 0) begin
                out_e = mq.pop_front();
                out_v = 1'b1;
            end else begin
                out_v = 1'b0;
            end
            if (m_acc && m_new.r != 5'd0) begin
                mq.push_back(m_new);
                sb.push_back(m_new);
            end
        end
    end

    // Monitor: pops the scoreboard on every presented write and checks status.
    always @(negedge clk) begin
        logic [31:0] exp_pend;
        ent_t        e;
        #1;
        if (RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("WriteRegister", 32'(WriteRegister), 32'(e.r));
                chk("WriteData", WriteData, e.d);
            end
        end
        chk("RegWrite", 32'(RegWrite), 32'(out_v));
        exp_pend = '0;
        foreach (mq[i]) exp_pend[mq[i].r] = 1'b1;
        if (out_v) exp_pend[out_e.r] = 1'b1;
        chk("pending", pending, exp_pend);
        chk("empty", 32'(empty), 32'(mq.size() == 0 && !out_v));
        if (!rst) begin
            chk("alu_ready", 32'(alu_ready), 32'(mq.size() < DEPTH));
            chk("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH && !alu_valid));
        end
    end

    task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md);
        @(negedge clk);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit done;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_RegWrite", 32'(RegWrite), 32'd0);
        chk("reset_WriteRegister", 32'(WriteRegister), 32'd0);
        chk("reset_WriteData", WriteData, 32'd0);
        chk("reset_pending", pending, 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        rst = 1'b0;

        // Single ALU write, exact latency.
        drive(1, 5, 32'h1234_5678, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("lat_pending5", 32'(pending[5]), 32'd1);
        chk("lat_RegWrite_early", 32'(RegWrite), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("lat_RegWrite", 32'(RegWrite), 32'd1);
        chk("lat_WriteData", WriteData, 32'h1234_5678);
        idle(1);
        #2;
        chk("lat_empty_after", 32'(empty), 32'd1);

        // ALU priority over load completion.
        drive(1, 3, 32'hA, 1, 4, 32'hB);
        #2;
        chk("prio_mem_ready", 32'(mem_ready), 32'd0);
        drive(0, 0, 0, 1, 4, 32'hB);
        idle(4);

        // Back-to-back ALU writes, held until accepted.
        for (int k = 1; k <= 6; k++) begin
            done = 0;
            for (int t = 0; t < 20 && !done; t++) begin
                drive(1, 5'(k), 32'(k * 16), 0, 0, 0);
                #1;
                done = alu_ready;
            end
            if (!done) chk("b2b_accept_timeout", 32'd0, 32'd1);
        end
        idle(4);

        // r0 writes are swallowed.
        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        #2;
        chk("r0_ready", 32'(alu_ready), 32'd1);
        idle(3);
        #2;
        chk("r0_empty", 32'(empty), 32'd1);

        // Duplicate destinations in order.
        drive(1, 7, 32'h1, 0, 0, 0);
        drive(1, 7, 32'h2, 0, 0, 0);
        idle(4);

        // Reset mid-operation.
        drive(1, 9, 32'h9, 0, 0, 0);
        drive(0, 0, 0, 1, 10, 32'hA);
        drive(1, 11, 32'hB, 0, 0, 0);
        do_reset();
        #2;
        chk("midrst_RegWrite", 32'(RegWrite), 32'd0);
        chk("midrst_pending", pending, 32'd0);
        idle(3);
        drive(1, 12, 32'hC, 0, 0, 0);
        idle(3);

        // Randomized traffic with narrow register range to provoke duplicates and r0.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            end
        end
        idle(6);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
